// File: rtl/start_fifo_srl_reader_pkg.sv
// Shared types and helpers for the start-token FIFO.
// Optional occupancy outputs are enabled with START_FIFO_OCC_EN.
package start_fifo_srl_reader_pkg;

  localparam int START_TOK_W = 1;

  typedef logic [START_TOK_W-1:0] start_tok_t;

  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/start_fifo_srl_store.sv
// Shift-register token storage; entry 0 is the newest token.
// No reset: contents are only meaningful below the occupancy count.
module start_fifo_srl_store
  import start_fifo_srl_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/start_fifo_srl_reader.sv
// Show-ahead start-token FIFO: occupancy, read address and flags.
// Define START_FIFO_OCC_EN for if_num_data_valid / if_almost_full.
module start_fifo_srl_reader
  import start_fifo_srl_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read_ce,
  input  logic                  if_read,
`ifdef START_FIFO_OCC_EN
  output logic                  if_empty_n,
  output logic [cnt_w(DEPTH)-1:0] if_num_data_valid,
  output logic                  if_almost_full
`else
  output logic                  if_empty_n
`endif
);

  localparam int CW = cnt_w(DEPTH);

  logic            push;
  logic            pop;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic            empty_n_q, empty_n_d;
  logic            full_n_q, full_n_d;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read & if_read_ce & empty_n_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // The newest token sits at entry 0, so the oldest is at cnt-1.
  always_comb begin
    addr_d = '0;
    if (cnt_d != '0) begin
      addr_d = ADDR_WIDTH'(cnt_d - CW'(1));
    end
  end

  assign empty_n_d = (cnt_d != '0);
  assign full_n_d  = (cnt_d != CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  assign if_empty_n = empty_n_q;
  assign if_full_n  = full_n_q;

`ifdef START_FIFO_OCC_EN
  logic almost_full_q, almost_full_d;

  assign almost_full_d = (cnt_d >= CW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign if_num_data_valid = cnt_q;
  assign if_almost_full    = almost_full_q;
`endif

  start_fifo_srl_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk  (clk),
    .we   (push),
    .addr (addr_q),
    .din  (if_din),
    .dout (if_dout)
  );

endmodule

// File: tb/tb_start_fifo_srl_reader.sv
// Directed bench for start_fifo_srl_reader, DEPTH=2, 1-bit tokens.
// Occupancy outputs are also checked when START_FIFO_OCC_EN is defined.
module tb_start_fifo_srl_reader;
  import start_fifo_srl_reader_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  start_tok_t if_din;
  logic       if_write_ce;
  logic       if_write;
  logic       if_full_n;
  start_tok_t if_dout;
  logic       if_read_ce;
  logic       if_read;
  logic       if_empty_n;
`ifdef START_FIFO_OCC_EN
  logic [1:0] if_num_data_valid;
  logic       if_almost_full;
`endif

  int checks = 0;
  int failures = 0;

  start_fifo_srl_reader #(
    .DATA_WIDTH (1),
    .ADDR_WIDTH (1),
    .DEPTH      (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_din      (if_din),
    .if_write_ce (if_write_ce),
    .if_write    (if_write),
    .if_full_n   (if_full_n),
    .if_dout     (if_dout),
    .if_read_ce  (if_read_ce),
    .if_read     (if_read),
`ifdef START_FIFO_OCC_EN
    .if_num_data_valid (if_num_data_valid),
    .if_almost_full    (if_almost_full),
`endif
    .if_empty_n  (if_empty_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int n);
    chk({tag, "_empty_n"}, 32'(if_empty_n), 32'(n != 0));
    chk({tag, "_full_n"}, 32'(if_full_n), 32'(n != 2));
`ifdef START_FIFO_OCC_EN
    chk({tag, "_ndv"}, 32'(if_num_data_valid), 32'(n));
    chk({tag, "_afull"}, 32'(if_almost_full), 32'(n >= 1));
`endif
  endtask

  logic last_din;

  initial begin
    reset = 1'b1;
    if_din = '0;
    if_write = 1'b0;
    if_write_ce = 1'b1;
    if_read = 1'b0;
    if_read_ce = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_cnt("reset", 0);

    if_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_cnt("idle_read", 0);
    end
    if_read = 1'b0;

    if_write = 1'b1;
    if_din = 1'b1;
    step();
    chk_cnt("push1", 1);
    chk("push1_dout", 32'(if_dout), 32'd1);

    if_din = 1'b0;
    step();
    chk_cnt("push2", 2);
    chk("push2_dout", 32'(if_dout), 32'd1);

    if_din = 1'b1;
    if_read = 1'b1;
    step();
    chk_cnt("full_wr_rd", 1);
    chk("full_wr_rd_dout", 32'(if_dout), 32'd0);

    for (int i = 0; i < 8; i++) begin
      if_din = (i % 2 == 0);
      last_din = if_din;
      step();
      chk_cnt("pushpop", 1);
      chk("pushpop_dout", 32'(if_dout), 32'(last_din));
    end

    if_write = 1'b1;
    if_write_ce = 1'b0;
    if_read = 1'b0;
    if_din = ~last_din;
    step();
    chk_cnt("wce0", 1);
    chk("wce0_dout", 32'(if_dout), 32'(last_din));

    if_write = 1'b0;
    if_write_ce = 1'b1;
    if_read = 1'b1;
    if_read_ce = 1'b0;
    step();
    chk_cnt("rce0", 1);
    chk("rce0_dout", 32'(if_dout), 32'(last_din));

    if_read = 1'b0;
    if_read_ce = 1'b1;
    if_write = 1'b1;
    if_din = 1'b1;
    step();
    chk_cnt("refill", 2);
    chk("refill_dout", 32'(if_dout), 32'(last_din));

    if_write = 1'b0;
    if_read = 1'b1;
    reset = 1'b1;
    step();
    chk_cnt("reset_pop", 0);

    reset = 1'b0;
    if_write = 1'b1;
    if_din = 1'b1;
    step();
    chk_cnt("empty_wr_rd", 1);
    chk("empty_wr_rd_dout", 32'(if_dout), 32'd1);

    if_write = 1'b0;
    step();
    chk_cnt("drain", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
